mpu6050_frame_assembler: RTL and testbench
==========================================

// Module: mpu6050_frame_assembler
// PURPOSE
//  Downstream consumer of the I2C master. Fires periodic 14-byte burst reads of MPU6050
//  regs 0x3B..0x48 and packs the big-endian bytes into seven signed 16-bit words:
//  ax, ay, az, temp, gx, gy, gz.
//  Publishes complete, validated frames to the pose-estimation stage over valid/ready.
// PARAMETERS
//  SAMPLE_DIV   12000  clocks between sample ticks (1 kHz at 12 MHz); must be >= 2
//  BURST_LEN    14     bytes per frame; fixed, must be even
//  TIMEOUT_CYC  4095   max clocks with no byte/done activity in COLLECT before abort
// PORTS
//  sys_clk_12m   in   1   sole clock
//  rst           in   1   synchronous, active-high reset
//  rd_req        out  1   burst-read request to I2C master; level, held until rd_ack
//  rd_ack        in   1   1-cycle pulse: master accepted request
//  rd_byte_vld   in   1   1-cycle pulse: rd_byte holds next read byte
//  rd_byte       in   8   read data byte
//  rd_done       in   1   1-cycle pulse: burst finished (STOP issued)
//  rd_nack       in   1   1-cycle pulse: slave NACK/bus error
//  frame_valid   out  1   frame outputs valid; held until frame_ready
//  frame_ready   in   1   consumer accepts frame when frame_valid & frame_ready
//  accel_x/y/z   out  16  signed accel words (3 ports)
//  temp          out  16  signed raw temperature
//  gyro_x/y/z    out  16  signed gyro words (3 ports)
//  overrun_cnt   out  8   saturating count of frames dropped (consumer not ready)
//  err_cnt       out  8   saturating count of aborted bursts (nack/short/long/timeout)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; tick counter=0; tick_pend=0; byte index=0.
//  Tick counter wraps at SAMPLE_DIV-1, sets tick_pend; extra ticks while pending coalesce.
//  FSM: IDLE  -tick_pend-> REQ (clear tick_pend, rd_req=1)
//       REQ   -rd_ack-> COLLECT (rd_req=0 same edge, idx=0, timer=0)
//       COLLECT: each rd_byte_vld: even idx -> hi latch; odd idx -> shadow[idx>>1]={hi,byte}; idx++
//         rd_done with idx==BURST_LEN -> PUBLISH; rd_done with idx!=BURST_LEN -> ABORT
//         byte when idx==BURST_LEN -> ABORT; rd_nack -> ABORT (priority over same-cycle byte/done)
//         timer reaches TIMEOUT_CYC -> ABORT; timer clears on any byte
//       PUBLISH (1 cycle): if !frame_valid or frame_ready this cycle: copy shadow -> outputs,
//         frame_valid=1; else drop frame, overrun_cnt++ (sat 255). -> IDLE
//       ABORT (1 cycle): err_cnt++ (sat 255), shadow untouched at outputs. -> IDLE
//  frame_valid clears on valid&ready unless PUBLISH reloads in the same cycle (stays 1).
//  Outputs stable while frame_valid=1 and not accepted. Latency rd_done -> frame_valid: 2 clks.
//  rst mid-burst: FSM to IDLE, rd_req drops; later I2C pulses ignored outside COLLECT.
// CONFIGURATION
//  MPU_GYRO_BIAS_CAL_EN defined: first successfully published frame after reset is captured
//   as gyro bias and NOT presented (frame_valid stays 0); subsequent gyro_x/y/z =
//   raw - bias, 16-bit wrap, computed in PUBLISH. Accel/temp unchanged.
//  Undefined: no bias registers; gyro outputs raw; first frame presented normally.
// STRUCTURE
//  Package mpu6050_pkg: FSM state enum, MPU_REG_ACCEL_XOUT_H=8'h3B, word-slot index consts
//   (SLOT_AX..SLOT_GZ), frame struct type.
//  Sub-module mpu6050_sample_tick: SAMPLE_DIV counter + tick_pend flag.
// TESTING
//  1 Reset, SAMPLE_DIV=100: rd_req rises cycle 100; ack; 14 bytes 01..0E; done ->
//    accel_x=0x0102, temp=0x0708, gyro_z=0x0D0E, frame_valid 2 clks after done.
//  2 frame_ready=0, two complete bursts -> first frame held unchanged, overrun_cnt=1;
//    ready pulse -> frame_valid=0.
//  3 rd_nack after byte 5 -> err_cnt=1, frame_valid stays 0, next tick issues new rd_req.
//  4 rd_done after 12 bytes -> err_cnt=1; 15 bytes before done -> err_cnt=2;
//    no bytes for TIMEOUT_CYC -> err_cnt=3.
//  5 rst asserted mid-COLLECT -> rd_req=0, all outputs 0; stray rd_byte_vld ignored.
//  6 MPU_GYRO_BIAS_CAL_EN: frame1 gx=0x0010 not presented; frame2 gx=0x0015 -> gyro_x=0x0005;
//    frame3 gx=0x0000 -> 0xFFF0.

Source files
------------

// File: rtl/mpu6050_pkg.sv
// mpu6050_pkg: shared FSM states, register map and frame layout for the MPU6050 frame assembler
package mpu6050_pkg;
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_COLLECT, S_PUBLISH, S_ABORT} state_t;
   localparam logic [7:0] MPU_REG_ACCEL_XOUT_H = 8'h3B;
   localparam int SLOT_AX   = 0;
   localparam int SLOT_AY   = 1;
   localparam int SLOT_AZ   = 2;
   localparam int SLOT_TEMP = 3;
   localparam int SLOT_GX   = 4;
   localparam int SLOT_GY   = 5;
   localparam int SLOT_GZ   = 6;
   typedef struct packed {
      logic [15:0] ax, ay, az, temp, gx, gy, gz;
   } frame_t;
endpackage

// File: rtl/mpu6050_frame_assembler_if.sv
// mpu6050_frame_assembler_if: I2C burst-read handshake plus frame valid/ready output bundle
//   master : the frame assembler (drives rd_req and all frame/counter outputs)
//   slave  : the surrounding I2C master and pose-estimation consumer
interface mpu6050_frame_assembler_if;
   logic        rd_req, rd_ack, rd_byte_vld, rd_done, rd_nack;
   logic [7:0]  rd_byte;
   logic        frame_valid, frame_ready;
   logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
   logic [7:0]  overrun_cnt, err_cnt;
   modport master (
      output rd_req, frame_valid, accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z,
             overrun_cnt, err_cnt,
      input  rd_ack, rd_byte_vld, rd_byte, rd_done, rd_nack, frame_ready
   );
   modport slave (
      input  rd_req, frame_valid, accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z,
             overrun_cnt, err_cnt,
      output rd_ack, rd_byte_vld, rd_byte, rd_done, rd_nack, frame_ready
   );
endinterface

// File: rtl/mpu6050_sample_tick.sv
// mpu6050_sample_tick: free-running SAMPLE_DIV divider with a sticky, coalescing tick-pending flag
//   sys_clk_12m in  clock
//   rst         in  synchronous active-high reset
//   clr         in  consumer took the pending tick
//   tick_pend   out a sample is due
module mpu6050_sample_tick #(
   parameter int SAMPLE_DIV = 12000
) (
   input  logic sys_clk_12m,
   input  logic rst,
   input  logic clr,
   output logic tick_pend
);
   localparam int CW = $clog2(SAMPLE_DIV);
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);
   logic [CW-1:0] cnt;
   logic wrap;
   assign wrap = (cnt == LAST);
   always_ff @(posedge sys_clk_12m) begin
      if (rst) begin
         cnt       <= '0;
         tick_pend <= 1'b0;
      end else begin
         cnt       <= wrap ? '0 : cnt + 1'b1;
         // a new tick wins over a same-cycle clear so no sample is lost
         tick_pend <= wrap | (tick_pend & ~clr);
      end
   end
endmodule

// File: rtl/mpu6050_frame_assembler.sv
// mpu6050_frame_assembler: periodic 14-byte MPU6050 burst reader packing big-endian words into validated frames
//   sys_clk_12m in  sole clock
//   rst         in  synchronous active-high reset
//   bus         master modport: rd_req/rd_ack/rd_byte_vld/rd_byte/rd_done/rd_nack from the I2C master,
//               frame_valid/frame_ready plus accel/temp/gyro words, overrun_cnt, err_cnt to the consumer
//   Optional MPU_GYRO_BIAS_CAL_EN: first good frame becomes the gyro bias and later gyro words are raw - bias.
module mpu6050_frame_assembler
   import mpu6050_pkg::*;
#(
   parameter int SAMPLE_DIV  = 12000,
   parameter int BURST_LEN   = 14,
   parameter int TIMEOUT_CYC = 4095
) (
   input logic sys_clk_12m,
   input logic rst,
   mpu6050_frame_assembler_if.master bus
);
   localparam int IW = $clog2(BURST_LEN + 2);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IW-1:0] LEN = IW'(BURST_LEN);
   localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC);
   state_t        state;
   logic          tick_pend, tick_clr, accept;
   logic [IW-1:0] idx, idx_nxt;
   logic [TW-1:0] timer;
   logic [7:0]    hi_byte;
   logic [15:0]   shadow [BURST_LEN/2];
   frame_t        raw, pub, out_frame;
`ifdef MPU_GYRO_BIAS_CAL_EN
   logic          bias_done;
   logic [15:0]   bias_gx, bias_gy, bias_gz;
`endif
   mpu6050_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .sys_clk_12m(sys_clk_12m),
      .rst        (rst),
      .clr        (tick_clr),
      .tick_pend  (tick_pend)
   );
   assign tick_clr = (state == S_IDLE) && tick_pend;
   assign accept   = !bus.frame_valid || bus.frame_ready;
   // done is judged against the count including any byte landing in the same cycle
   assign idx_nxt  = idx + IW'(bus.rd_byte_vld);
   always_comb begin
      raw = '{ax: shadow[SLOT_AX], ay: shadow[SLOT_AY], az: shadow[SLOT_AZ], temp: shadow[SLOT_TEMP],
              gx: shadow[SLOT_GX], gy: shadow[SLOT_GY], gz: shadow[SLOT_GZ]};
      pub = raw;
`ifdef MPU_GYRO_BIAS_CAL_EN
      pub.gx = raw.gx - bias_gx;
      pub.gy = raw.gy - bias_gy;
      pub.gz = raw.gz - bias_gz;
`endif
   end
   always_ff @(posedge sys_clk_12m) begin
      if (rst) begin
         state           <= S_IDLE;
         idx             <= '0;
         timer           <= '0;
         hi_byte         <= '0;
         out_frame       <= '0;
         bus.rd_req      <= 1'b0;
         bus.frame_valid <= 1'b0;
         bus.overrun_cnt <= '0;
         bus.err_cnt     <= '0;
         for (int i = 0; i < BURST_LEN/2; i++) shadow[i] <= '0;
`ifdef MPU_GYRO_BIAS_CAL_EN
         bias_done <= 1'b0;
         bias_gx   <= '0;
         bias_gy   <= '0;
         bias_gz   <= '0;
`endif
      end else begin
         // PUBLISH below may re-assert valid in the same cycle
         if (bus.frame_valid && bus.frame_ready) bus.frame_valid <= 1'b0;
         case (state)
            S_IDLE: if (tick_pend) begin
               state      <= S_REQ;
               bus.rd_req <= 1'b1;
            end
            S_REQ: if (bus.rd_ack) begin
               state      <= S_COLLECT;
               bus.rd_req <= 1'b0;
               idx        <= '0;
               timer      <= '0;
            end
            S_COLLECT: begin
               if (bus.rd_byte_vld) begin
                  timer <= '0;
                  idx   <= idx_nxt;
                  if (idx[0]) shadow[idx[IW-1:1]] <= {hi_byte, bus.rd_byte};
                  else hi_byte <= bus.rd_byte;
               end else begin
                  timer <= timer + 1'b1;
               end
               if (bus.rd_nack || (bus.rd_byte_vld && idx == LEN) || (bus.rd_done && idx_nxt != LEN) ||
                   (!bus.rd_byte_vld && timer == TMO)) state <= S_ABORT;
               else if (bus.rd_done) state <= S_PUBLISH;
            end
            S_PUBLISH: begin
               state <= S_IDLE;
               if (accept) begin
`ifdef MPU_GYRO_BIAS_CAL_EN
                  if (!bias_done) begin
                     bias_done <= 1'b1;
                     bias_gx   <= raw.gx;
                     bias_gy   <= raw.gy;
                     bias_gz   <= raw.gz;
                  end else begin
                     out_frame       <= pub;
                     bus.frame_valid <= 1'b1;
                  end
`else
                  out_frame       <= pub;
                  bus.frame_valid <= 1'b1;
`endif
               end else if (bus.overrun_cnt != 8'hFF) begin
                  bus.overrun_cnt <= bus.overrun_cnt + 1'b1;
               end
            end
            S_ABORT: begin
               state <= S_IDLE;
               if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
   assign bus.accel_x = out_frame.ax;
   assign bus.accel_y = out_frame.ay;
   assign bus.accel_z = out_frame.az;
   assign bus.temp    = out_frame.temp;
   assign bus.gyro_x  = out_frame.gx;
   assign bus.gyro_y  = out_frame.gy;
   assign bus.gyro_z  = out_frame.gz;
endmodule

// File: tb/tb_mpu6050_frame_assembler.sv
// tb_mpu6050_frame_assembler: randomized burst scenarios checked against a frame-level reference model
module tb_mpu6050_frame_assembler;
   localparam int SD = 100, BL = 14, TMO = 4095;
`ifdef MPU_GYRO_BIAS_CAL_EN
   localparam bit BIAS = 1'b1;
`else
   localparam bit BIAS = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   mpu6050_frame_assembler_if bus ();
   mpu6050_frame_assembler #(.SAMPLE_DIV(SD), .BURST_LEN(BL), .TIMEOUT_CYC(TMO)) dut (
      .sys_clk_12m(clk),
      .rst        (rst),
      .bus        (bus)
   );
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   logic [7:0]   bq [16];
   logic [111:0] m_frame;
   logic         m_valid, m_bias_done;
   logic [7:0]   m_over, m_err;
   logic [47:0]  m_bias;
   logic         req_ok, req_after_ack, v1, v2;
   function automatic logic [111:0] dut_frame();
      return {bus.accel_x, bus.accel_y, bus.accel_z, bus.temp, bus.gyro_x, bus.gyro_y, bus.gyro_z};
   endfunction
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic model_reset();
      m_frame = '0; m_valid = 1'b0; m_over = '0; m_err = '0; m_bias_done = 1'b0; m_bias = '0;
   endtask
   task automatic fill_rand();
      for (int i = 0; i < 16; i++) bq[i] = 8'($urandom);
   endtask
   task automatic wait_req();
      int n = 0;
      while (bus.rd_req !== 1'b1 && n < 4*SD) begin
         step(1);
         n++;
      end
      req_ok = (bus.rd_req === 1'b1);
   endtask
   // kind 0: bytes then done, 1: bytes then nack, 2: silence until timeout
   task automatic run_burst(input int kind, input int nb, input logic rdy);
      logic [111:0] f;
      bus.frame_ready = rdy;
      if (rdy) m_valid = 1'b0;
      wait_req();
      if (!req_ok) begin
         tests++; fails++;
         $display("FAIL req_wait: rd_req=%b required 1 within %0d cycles", bus.rd_req, 4*SD);
         return;
      end
      bus.rd_ack = 1'b1; step(1); bus.rd_ack = 1'b0;
      req_after_ack = bus.rd_req;
      if (kind == 2) step(TMO + 20);
      else begin
         for (int i = 0; i < nb; i++) begin
            step($urandom_range(0, 2));
            bus.rd_byte = bq[i]; bus.rd_byte_vld = 1'b1; step(1); bus.rd_byte_vld = 1'b0;
         end
         if (kind == 1) bus.rd_nack = 1'b1; else bus.rd_done = 1'b1;
         step(1);
         bus.rd_nack = 1'b0; bus.rd_done = 1'b0;
      end
      v1 = bus.frame_valid; step(1); v2 = bus.frame_valid; step(2);
      if (kind != 0 || nb != BL) m_err = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
      else begin
         for (int i = 0; i < 7; i++) f[111-16*i -: 16] = {bq[2*i], bq[2*i+1]};
         if (BIAS && !m_bias_done) begin
            m_bias_done = 1'b1;
            m_bias = f[47:0];
         end else begin
            if (BIAS) f[47:0] = {f[47:32] - m_bias[47:32], f[31:16] - m_bias[31:16], f[15:0] - m_bias[15:0]};
            if (!m_valid || rdy) begin
               m_frame = f;
               m_valid = !rdy;
            end else m_over = (m_over == 8'hFF) ? m_over : m_over + 8'd1;
         end
      end
   endtask
   task automatic test_reset();
      int n = 0;
      rst = 1'b1; step(3);
      tests += 5;
      if (bus.rd_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", bus.rd_req); end
      if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.frame_valid); end
      if (dut_frame() !== '0) begin fails++; $display("FAIL rst_frame: got %h want 0", dut_frame()); end
      if (bus.overrun_cnt !== 8'd0) begin fails++; $display("FAIL rst_over: got %0d want 0", bus.overrun_cnt); end
      if (bus.err_cnt !== 8'd0) begin fails++; $display("FAIL rst_err: got %0d want 0", bus.err_cnt); end
      rst = 1'b0;
      while (bus.rd_req !== 1'b1 && n < 4*SD) begin
         step(1);
         n++;
      end
      tests++;
      if (n < SD || n > SD + 1) begin fails++; $display("FAIL first_tick: rd_req after %0d cycles want %0d..%0d", n, SD, SD + 1); end
   endtask
   task automatic test_basic();
      for (int i = 0; i < 16; i++) bq[i] = 8'(i + 1);
      run_burst(0, BL, 1'b0);
      tests += 5;
      if (req_after_ack !== 1'b0) begin fails++; $display("FAIL req_drop: got %b want 0", req_after_ack); end
      if (v1 !== 1'b0) begin fails++; $display("FAIL lat1: valid %b want 0 one clk after done", v1); end
      if (v2 !== m_valid) begin fails++; $display("FAIL lat2: valid %b want %b two clks after done", v2, m_valid); end
      if (dut_frame() !== m_frame) begin fails++; $display("FAIL basic_frame: got %h want %h", dut_frame(), m_frame); end
      if (bus.frame_valid !== m_valid) begin fails++; $display("FAIL basic_valid: got %b want %b", bus.frame_valid, m_valid); end
      bus.frame_ready = 1'b1; step(1); bus.frame_ready = 1'b0; m_valid = 1'b0;
      tests++;
      if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL basic_accept: valid %b want 0", bus.frame_valid); end
   endtask
   task automatic test_overrun();
      fill_rand(); run_burst(0, BL, 1'b0);
      fill_rand(); run_burst(0, BL, 1'b0);
      tests += 3;
      if (dut_frame() !== m_frame) begin fails++; $display("FAIL held_frame: got %h want %h", dut_frame(), m_frame); end
      if (bus.frame_valid !== m_valid) begin fails++; $display("FAIL held_valid: got %b want %b", bus.frame_valid, m_valid); end
      if (bus.overrun_cnt !== m_over) begin fails++; $display("FAIL overrun: got %0d want %0d", bus.overrun_cnt, m_over); end
      bus.frame_ready = 1'b1; step(1); bus.frame_ready = 1'b0; m_valid = 1'b0;
      tests++;
      if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL overrun_accept: valid %b want 0", bus.frame_valid); end
   endtask
   task automatic test_nack();
      fill_rand(); run_burst(1, 5, 1'b0);
      tests += 3;
      if (bus.err_cnt !== m_err) begin fails++; $display("FAIL nack_err: got %0d want %0d", bus.err_cnt, m_err); end
      if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL nack_valid: got %b want 0", bus.frame_valid); end
      wait_req();
      if (req_ok !== 1'b1) begin fails++; $display("FAIL nack_rereq: rd_req %b want 1", bus.rd_req); end
   endtask
   task automatic test_length_timeout();
      fill_rand(); run_burst(0, 12, 1'b0);
      tests++;
      if (bus.err_cnt !== m_err) begin fails++; $display("FAIL short_err: got %0d want %0d", bus.err_cnt, m_err); end
      fill_rand(); run_burst(0, 15, 1'b0);
      tests++;
      if (bus.err_cnt !== m_err) begin fails++; $display("FAIL long_err: got %0d want %0d", bus.err_cnt, m_err); end
      run_burst(2, 0, 1'b0);
      tests += 2;
      if (bus.err_cnt !== m_err) begin fails++; $display("FAIL timeout_err: got %0d want %0d", bus.err_cnt, m_err); end
      if (dut_frame() !== m_frame) begin fails++; $display("FAIL abort_frame: got %h want %h", dut_frame(), m_frame); end
   endtask
   task automatic test_reset_mid();
      wait_req();
      bus.rd_ack = 1'b1; step(1); bus.rd_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.rd_byte = 8'($urandom); bus.rd_byte_vld = 1'b1; step(1); bus.rd_byte_vld = 1'b0;
      end
      rst = 1'b1; step(1);
      model_reset();
      tests += 3;
      if (bus.rd_req !== 1'b0) begin fails++; $display("FAIL midrst_req: got %b want 0", bus.rd_req); end
      if (dut_frame() !== m_frame) begin fails++; $display("FAIL midrst_frame: got %h want %h", dut_frame(), m_frame); end
      if (bus.err_cnt !== m_err || bus.overrun_cnt !== m_over) begin
         fails++; $display("FAIL midrst_cnt: err %0d over %0d want 0 0", bus.err_cnt, bus.overrun_cnt);
      end
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bus.rd_byte = 8'($urandom); bus.rd_byte_vld = 1'b1; step(1); bus.rd_byte_vld = 1'b0;
      end
      bus.rd_done = 1'b1; step(1); bus.rd_done = 1'b0; step(3);
      tests += 3;
      if (bus.frame_valid !== 1'b0) begin fails++; $display("FAIL stray_valid: got %b want 0", bus.frame_valid); end
      if (bus.err_cnt !== 8'd0) begin fails++; $display("FAIL stray_err: got %0d want 0", bus.err_cnt); end
      if (bus.rd_req !== 1'b0) begin fails++; $display("FAIL stray_req: got %b want 0", bus.rd_req); end
   endtask
`ifdef MPU_GYRO_BIAS_CAL_EN
   task automatic test_bias();
      fill_rand(); bq[8] = 8'h00; bq[9] = 8'h10;
      run_burst(0, BL, 1'b1);
      tests++;
      if (v2 !== 1'b0 || bus.frame_valid !== 1'b0) begin fails++; $display("FAIL bias_hidden: valid %b want 0", bus.frame_valid); end
      fill_rand(); bq[8] = 8'h00; bq[9] = 8'h15;
      run_burst(0, BL, 1'b0);
      tests += 2;
      if (bus.gyro_x !== 16'h0005) begin fails++; $display("FAIL bias_gx2: got %h want 0005", bus.gyro_x); end
      if (dut_frame() !== m_frame) begin fails++; $display("FAIL bias_frame2: got %h want %h", dut_frame(), m_frame); end
      bus.frame_ready = 1'b1; step(1); bus.frame_ready = 1'b0; m_valid = 1'b0;
      fill_rand(); bq[8] = 8'h00; bq[9] = 8'h00;
      run_burst(0, BL, 1'b0);
      tests++;
      if (bus.gyro_x !== 16'hFFF0) begin fails++; $display("FAIL bias_gx3: got %h want fff0", bus.gyro_x); end
   endtask
`endif
   task automatic test_back_to_back();
      for (int it = 0; it < 10; it++) begin
         int r, nb, kind;
         logic rdy;
         r = $urandom_range(0, 5);
         rdy = 1'($urandom_range(0, 1));
         kind = (r == 5) ? 1 : 0;
         nb = (r <= 2) ? BL : (r == 3) ? $urandom_range(1, 13) : (r == 4) ? 15 : $urandom_range(0, 13);
         fill_rand();
         run_burst(kind, nb, rdy);
         tests += 4;
         if (bus.frame_valid !== m_valid) begin fails++; $display("FAIL b2b%0d_valid: got %b want %b", it, bus.frame_valid, m_valid); end
         if (dut_frame() !== m_frame) begin fails++; $display("FAIL b2b%0d_frame: got %h want %h", it, dut_frame(), m_frame); end
         if (bus.overrun_cnt !== m_over) begin fails++; $display("FAIL b2b%0d_over: got %0d want %0d", it, bus.overrun_cnt, m_over); end
         if (bus.err_cnt !== m_err) begin fails++; $display("FAIL b2b%0d_err: got %0d want %0d", it, bus.err_cnt, m_err); end
      end
   endtask
   initial begin
      bus.rd_ack = 1'b0; bus.rd_byte_vld = 1'b0; bus.rd_byte = '0;
      bus.rd_done = 1'b0; bus.rd_nack = 1'b0; bus.frame_ready = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_overrun();
      test_nack();
      test_length_timeout();
      test_reset_mid();
`ifdef MPU_GYRO_BIAS_CAL_EN
      test_bias();
`endif
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end
endmodule
